// File: rtl/seg7_capture.sv
// seg7_capture: debounces a 7-segment bus, decodes settled glyphs to hex and queues them in a valid/ready FIFO.
// Optional macro SEG7_CAPTURE_DEDUP_EN suppresses repeats of the last pushed glyph until a blank is seen.
module seg7_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [6:0]               segments,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_nibble,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {UNSTABLE, COUNTING, HELD} state_t;
   state_t st;
   logic [6:0] s;
   logic [7:0] cnt;
   logic acc, dup, push, pop, full, wr;
   logic [4:0] fifo [DEPTH];
   logic [AW-1:0] wp, rp;
   function automatic logic [4:0] decode(input logic [6:0] g);
      logic [4:0] r;
      case (g)
         7'h3F: r = 5'h00;
         7'h06: r = 5'h01;
         7'h5B: r = 5'h02;
         7'h4F: r = 5'h03;
         7'h66: r = 5'h04;
         7'h6D: r = 5'h05;
         7'h7D: r = 5'h06;
         7'h07: r = 5'h07;
         7'h7F: r = 5'h08;
         7'h6F: r = 5'h09;
         7'h77: r = 5'h0A;
         7'h7C: r = 5'h0B;
         7'h39: r = 5'h0C;
         7'h5E: r = 5'h0D;
         7'h79: r = 5'h0E;
         7'h71: r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction
   // acc is a registered one-shot on entry to HELD; the push happens on the following edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= UNSTABLE;
         s <= '0;
         cnt <= '0;
         acc <= 1'b0;
      end else if (segments != s) begin
         st <= UNSTABLE;
         s <= segments;
         cnt <= 8'd1;
         acc <= 1'b0;
      end else if (st != HELD && cnt == 8'(STABLE_CYCLES - 1)) begin
         st <= HELD;
         cnt <= 8'(STABLE_CYCLES);
         acc <= 1'b1;
      end else if (st != HELD) begin
         st <= COUNTING;
         cnt <= cnt + 8'd1;
         acc <= 1'b0;
      end else
         acc <= 1'b0;
`ifdef SEG7_CAPTURE_DEDUP_EN
   logic [6:0] last;
   logic last_v;
   assign dup = last_v && last == s;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         last <= '0;
         last_v <= 1'b0;
      end else if (acc && s == 7'h00)
         last_v <= 1'b0;
      else if (acc && !dup) begin
         last <= s;
         last_v <= 1'b1;
      end
`else
   assign dup = 1'b0;
`endif
   always_comb begin
      push = acc && s != 7'h00 && !dup;
      out_valid = level != '0;
      pop = out_valid && out_ready;
      full = level == (AW+1)'(DEPTH);
      wr = push && (!full || pop);
      out_nibble = fifo[rp][3:0];
      out_err = fifo[rp][4];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
         wp <= '0;
         rp <= '0;
         level <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            fifo[wp] <= decode(s);
            wp <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         if (push && full && !pop) overflow <= 1'b1;
         level <= level + (AW+1)'(wr) - (AW+1)'(pop);
      end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed stimulus with a scoreboard queue checked by an independent pop monitor.
module tb_seg7_capture;
   logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
   logic [6:0] segments = 7'h00;
   logic out_valid, out_err, overflow;
   logic [3:0] out_nibble;
   logic [2:0] level;
   int tests = 0, fails = 0;
   logic [4:0] exp_q [$];
   logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   seg7_capture #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .segments(segments), .out_valid(out_valid), .out_ready(out_ready),
      .out_nibble(out_nibble), .out_err(out_err), .level(level), .overflow(overflow));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask
   task automatic glyph(input logic [6:0] g, input int n);
      segments = g;
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic drain();
      int k = 0;
      out_ready = 1'b1;
      while (level != 0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_timeout", int'(level), 0);
   endtask
   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_entry", {out_err, out_nibble}, -1);
         else begin
            logic [4:0] e;
            e = exp_q.pop_front();
            chk("entry", {out_err, out_nibble}, e);
         end
      end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      // partial run interrupted by reset
      glyph(7'h06, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      glyph(7'h06, 3);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_nibble", out_nibble, 0);
      chk("midrst_err", out_err, 0);
      chk("midrst_level", level, 0);
      chk("midrst_overflow", overflow, 0);
      glyph(7'h00, 6);
      // latency: visible exactly after the 5th edge (k+4)
      exp_q.push_back(5'h00);
      glyph(7'h3F, 4);
      chk("lat_early_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_valid", out_valid, 1);
      chk("lat_nibble", out_nibble, 0);
      chk("lat_err", out_err, 0);
      chk("lat_level", level, 1);
      out_ready = 1'b1;
      glyph(7'h00, 6);
      // glitch rejection, invalid glyph, blank separation
      exp_q.push_back(5'h0E);
      glyph(7'h6D, 3);
      glyph(7'h79, 6);
      glyph(7'h00, 6);
      exp_q.push_back(5'h10);
      glyph(7'h49, 6);
      glyph(7'h00, 6);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      glyph(7'h4F, 6);
      glyph(7'h00, 6);
      glyph(7'h4F, 6);
      glyph(7'h00, 6);
      // dedup of a glitch-and-return
      exp_q.push_back(5'h02);
`ifndef SEG7_CAPTURE_DEDUP_EN
      exp_q.push_back(5'h02);
`endif
      glyph(7'h5B, 6);
      glyph(7'h5A, 1);
      glyph(7'h5B, 6);
      glyph(7'h00, 6);
      // full decode table
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(5'(i));
         glyph(glyphs[i], 5);
         glyph(7'h00, 5);
      end
      // overflow: fifth push dropped
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) exp_q.push_back(5'(i));
      for (int i = 1; i <= 5; i++) glyph(glyphs[i], 5);
      chk("ovf_level", level, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_head", out_nibble, 1);
      glyph(7'h00, 2);
      drain();
      chk("ovf_sticky", overflow, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("ovf_rst_clear", overflow, 0);
      // fifth push coincides with a pop: retained
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) exp_q.push_back(5'(i));
      for (int i = 1; i <= 4; i++) glyph(glyphs[i], 5);
      chk("full_level", level, 4);
      glyph(glyphs[5], 4);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("simul_level", level, 4);
      chk("simul_overflow", overflow, 0);
      glyph(7'h00, 2);
      drain();
      glyph(7'h00, 4);
      chk("queue_left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
